multi_cycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset datapath: addu, lw, sw, beq, j, addiu.
Replaces single-cycle decode with per-state Moore control, so one ALU and one unified memory port are shared across cycles.
Waits on a memory ready handshake, counts retired instructions, and flags unsupported encodings.
Sits between the instruction register (op/funct fields) and the datapath muxes, enables and ALU.

---
 rtl/multi_cycle_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle Moore control for the MIPS subset addu/lw/sw/beq/j/addiu.
// Shares one ALU and one memory port across states; counts retirements.
module multi_cycle_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    input  logic               alu_zero,
    output logic               pc_wen,
    output logic [1:0]         pc_src,
    output logic               ir_wen,
    output logic               iord,
    output logic               mem_ren,
    output logic               mem_wen,
    output logic               rf_wen,
    output logic               rf_dst,
    output logic               mem_to_rf,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [3:0]         alu_ctrl,
    output logic [3:0]         state,
    output logic               retire,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_e             state_q, state_d;
    logic               is_sw_q, is_sw_d;
    logic [COUNT_W-1:0] cnt_q;

    logic op_r, op_lw, op_sw, op_beq, op_j, op_addi, fn_addu;

    assign op_r    = (op == 6'b000000);
    assign op_lw   = (op == 6'b100011);
    assign op_sw   = (op == 6'b101011);
    assign op_beq  = (op == 6'b000100);
    assign op_j    = (op == 6'b000010);
    assign op_addi = (op == 6'b001001);
    assign fn_addu = (funct == 6'b100001);

    always_comb begin
        state_d   = S_FETCH;
        is_sw_d   = is_sw_q;
        pc_wen    = 1'b0;
        pc_src    = 2'b00;
        ir_wen    = 1'b0;
        iord      = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        rf_wen    = 1'b0;
        rf_dst    = 1'b0;
        mem_to_rf = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_ctrl  = 4'b0000;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_ren = 1'b1;
                if (mem_ready) begin
                    ir_wen    = 1'b1;
                    pc_wen    = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    state_d   = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut here.
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                unique case (1'b1)
                    op_r && fn_addu: state_d = S_EXEC;
                    op_lw: begin
                        state_d = S_MEM_ADDR;
                        is_sw_d = 1'b0;
                    end
                    op_sw: begin
                        state_d = S_MEM_ADDR;
                        is_sw_d = 1'b1;
                    end
                    op_beq:  state_d = S_BRANCH;
                    op_j:    state_d = S_JUMP;
                    op_addi: state_d = S_ADDI_EX;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = is_sw_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_ren = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                rf_wen    = 1'b1;
                mem_to_rf = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_WR: begin
                mem_wen = 1'b1;
                iord    = 1'b1;
                retire  = mem_ready;
                state_d = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_ADD;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                rf_wen = 1'b1;
                rf_dst = 1'b1;
                retire = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_wen    = alu_zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_wen = 1'b1;
                pc_src = 2'b10;
                retire = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                rf_wen = 1'b1;
                retire = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset squashes every request, including a pending memory write.
        if (!rst) begin
            pc_wen    = 1'b0;
            pc_src    = 2'b00;
            ir_wen    = 1'b0;
            iord      = 1'b0;
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
            rf_wen    = 1'b0;
            rf_dst    = 1'b0;
            mem_to_rf = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            alu_ctrl  = 4'b0000;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
            if (retire) begin
                cnt_q <= cnt_q + COUNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_multi_cycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic          mem_ready;
    logic          alu_zero;
    logic          pc_wen;
    logic [1:0]    pc_src;
    logic          ir_wen;
    logic          iord;
    logic          mem_ren;
    logic          mem_wen;
    logic          rf_wen;
    logic          rf_dst;
    logic          mem_to_rf;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [3:0]    alu_ctrl;
    logic [3:0]    state;
    logic          retire;
    logic          illegal;
    logic [CW-1:0] instr_count;

    multi_cycle_ctrl #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
        .pc_wen(pc_wen), .pc_src(pc_src), .ir_wen(ir_wen),
        .iord(iord), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .rf_wen(rf_wen), .rf_dst(rf_dst), .mem_to_rf(mem_to_rf),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .state(state), .retire(retire),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          st;
        logic [16:0] ctl;
        bit          ret;
        bit          ill;
        int          cnt;
    } cyc_t;

    cyc_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   model_cnt = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ctl_vec();
        return {pc_wen, pc_src, ir_wen, iord, mem_ren, mem_wen, rf_wen,
                rf_dst, mem_to_rf, alu_src_a, alu_src_b, alu_ctrl};
    endfunction

    // Expected control word per state, straight from the state table.
    function automatic logic [16:0] exp_ctl(input int s, input bit mr, input bit z);
        logic pw, irw, io, mrn, mw, rw, rd, m2r, sa;
        logic [1:0] ps, sb;
        logic [3:0] ac;
        {pw, irw, io, mrn, mw, rw, rd, m2r, sa} = '0;
        ps = 2'd0; sb = 2'd0; ac = 4'd0;
        case (s)
            0: begin
                mrn = 1'b1;
                if (mr) begin irw = 1'b1; pw = 1'b1; sb = 2'd1; ac = 4'd2; end
            end
            1: begin sb = 2'd3; ac = 4'd2; end
            2: begin sa = 1'b1; sb = 2'd2; ac = 4'd2; end
            3: begin mrn = 1'b1; io = 1'b1; end
            4: begin rw = 1'b1; m2r = 1'b1; end
            5: begin mw = 1'b1; io = 1'b1; end
            6: begin sa = 1'b1; ac = 4'd2; end
            7: begin rw = 1'b1; rd = 1'b1; end
            8: begin sa = 1'b1; ac = 4'd6; ps = 2'd1; pw = z; end
            9: begin pw = 1'b1; ps = 2'd2; end
            10: begin sa = 1'b1; sb = 2'd2; ac = 4'd2; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pw, ps, irw, io, mrn, mw, rw, rd, m2r, sa, sb, ac};
    endfunction

    // Issue one instruction; its cycle-by-cycle trace is derived from the opcode.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int wf, input int wm, input bit z);
        int  seq[$];
        bit  bad;
        int  mem_done;
        cyc_t c;
        bad = 1'b0;
        mem_done = wf + 3 + wm;
        repeat (wf + 1) seq.push_back(0);
        seq.push_back(1);
        case (o)
            6'b000000: if (f == 6'b100001) begin
                seq.push_back(6); seq.push_back(7);
            end else bad = 1'b1;
            6'b100011: begin
                seq.push_back(2);
                repeat (wm + 1) seq.push_back(3);
                seq.push_back(4);
            end
            6'b101011: begin
                seq.push_back(2);
                repeat (wm + 1) seq.push_back(5);
            end
            6'b000100: seq.push_back(8);
            6'b000010: seq.push_back(9);
            6'b001001: begin seq.push_back(10); seq.push_back(11); end
            default: bad = 1'b1;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            logic mr;
            if (seq[i] == 0) mr = (i == wf);
            else if (seq[i] == 3 || seq[i] == 5) mr = (i == mem_done);
            else mr = 1'($urandom_range(0, 1));
            op = o; funct = f; mem_ready = mr; alu_zero = z;
            c.st  = seq[i];
            c.ctl = exp_ctl(seq[i], mr, z);
            c.ill = (i == seq.size() - 1) && bad;
            c.ret = (i == seq.size() - 1) && !bad;
            c.cnt = model_cnt;
            sbq.push_back(c);
            if (c.ret) model_cnt = (model_cnt + 1) % (1 << CW);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && sbq.size() > 0) begin
            cyc_t e;
            e = sbq.pop_front();
            chk("state", int'(state), e.st);
            chk("ctl", int'(ctl_vec()), int'(e.ctl));
            chk("retire", int'(retire), int'(e.ret));
            chk("illegal", int'(illegal), int'(e.ill));
            chk("instr_count", int'(instr_count), e.cnt);
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b0; mem_ready = 1'b1; op = 6'b000000; funct = 6'b100000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ctl", int'(ctl_vec()), 0);
        chk("rst_retire", int'(retire), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(instr_count), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_cnt = 0;
        mon_en = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 20) begin
            @(negedge clk); n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        rst = 1'b0; op = '0; funct = '0; mem_ready = 1'b0; alu_zero = 1'b0;
        do_reset();
        run_instr(6'b000000, 6'b100001, 0, 0, 1'b0);
        drain();
        chk("addu_count", int'(instr_count), 1);
        run_instr(6'b100011, 6'b000000, 0, 2, 1'b0);
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b1);
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b0);
        run_instr(6'b111111, 6'b000000, 0, 0, 1'b0);
        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);
        run_instr(6'b101011, 6'b000000, 1, 1, 1'b0);
        run_instr(6'b001001, 6'b000000, 0, 0, 1'b0);
        drain();
        do_reset();
        repeat (17) run_instr(6'b000010, 6'($urandom), 0, 0, 1'($urandom));
        drain();
        chk("wrap_count", int'(instr_count), 1);
        for (int n = 0; n < 300; n++) begin
            logic [5:0] o, f;
            int pick;
            pick = $urandom_range(0, 7);
            f = 6'($urandom);
            case (pick)
                0: begin o = 6'b000000; f = 6'b100001; end
                1: o = 6'b100011;
                2: o = 6'b101011;
                3: o = 6'b000100;
                4: o = 6'b000010;
                5: o = 6'b001001;
                6: o = 6'($urandom);
                default: o = 6'b000000;
            endcase
            run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom));
        end
        drain();
        // sw interrupted by reset while waiting on memory
        mon_en = 1'b0;
        op = 6'b101011; funct = '0; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("sw_wait_state", int'(state), 5);
        chk("sw_wait_wen", int'(mem_wen), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("sw_rst_wen", int'(mem_wen), 0);
        chk("sw_rst_retire", int'(retire), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("sw_rst_state", int'(state), 0);
        chk("sw_rst_count", int'(instr_count), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule
